// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq : sequential non-restoring integer divider (one quotient bit/cycle)
//
// Computes quotient and remainder of dividend/divisor in signed
// (two's-complement, truncating toward zero) or unsigned mode. Uses a
// start/busy/done handshake. Results stay stable until the next operation
// completes.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   start        in   request a division (sampled only while idle)
//   is_signed    in   1 = signed operands, 0 = unsigned (latched with start)
//   dividend     in   [WIDTH-1:0] numerator (latched with start)
//   divisor      in   [WIDTH-1:0] denominator (latched with start)
//   busy         out  high while an operation is in progress
//   done         out  one-cycle pulse when results become valid
//   quotient     out  [WIDTH-1:0] result quotient
//   remainder    out  [WIDTH-1:0] result remainder
//   div_by_zero  out  divisor was zero for the current result
//
// Build option:
//   DIV_ZERO_FAST_EN  when defined, a zero divisor skips the iteration phase
//                     and completes with 2-cycle latency. When undefined,
//                     every operation takes WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   // Partial remainder is one bit wider than the operands so that it can hold
   // both signs of a value in [-|D|, |D|) for any |D| up to 2^WIDTH-1.
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] qacc_q;      // dividend magnitude shifting out, quotient in
   logic [WIDTH-1:0] dmag_q;      // divisor magnitude
   logic [WIDTH-1:0] dvd_q;       // raw dividend, returned on divide by zero
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic             dbz_q;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quo_out_q;
   logic [WIDTH-1:0] rem_out_q;
   logic             dbz_out_q;

   logic             dvd_neg_d;
   logic             dsr_neg_d;
   logic             dsr_zero_d;
   logic [WIDTH-1:0] dvd_mag_d;
   logic [WIDTH-1:0] dsr_mag_d;
   logic [WIDTH:0]   rem_shift_d;
   logic [WIDTH:0]   rem_step_d;
   logic [WIDTH-1:0] qacc_step_d;
   logic [WIDTH:0]   rem_fix_d;
   logic [WIDTH-1:0] quo_res_d;
   logic [WIDTH-1:0] rem_res_d;

   always_comb begin
      // Operand magnitudes; in unsigned mode the MSB is plain magnitude.
      dvd_neg_d  = is_signed & dividend[WIDTH-1];
      dsr_neg_d  = is_signed & divisor[WIDTH-1];
      dsr_zero_d = (divisor == '0);
      dvd_mag_d  = dvd_neg_d ? -dividend : dividend;
      dsr_mag_d  = dsr_neg_d ? -divisor  : divisor;

      // One non-restoring step. Modular WIDTH+1 arithmetic is exact here
      // because the step result always lands back in [-|D|, |D|).
      rem_shift_d = {rem_q[WIDTH-1:0], qacc_q[WIDTH-1]};
      if (rem_q[WIDTH]) begin
         rem_step_d = rem_shift_d + {1'b0, dmag_q};
      end else begin
         rem_step_d = rem_shift_d - {1'b0, dmag_q};
      end
      qacc_step_d = {qacc_q[WIDTH-2:0], ~rem_step_d[WIDTH]};

      // Final correction of a negative remainder, then sign application.
      rem_fix_d = rem_q[WIDTH] ? (rem_q + {1'b0, dmag_q}) : rem_q;
      quo_res_d = neg_quo_q ? -qacc_q : qacc_q;
      rem_res_d = neg_rem_q ? -rem_fix_d[WIDTH-1:0] : rem_fix_d[WIDTH-1:0];
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         qacc_q    <= '0;
         dmag_q    <= '0;
         dvd_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         quo_out_q <= '0;
         rem_out_q <= '0;
         dbz_out_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  dvd_q     <= dividend;
                  qacc_q    <= dvd_mag_d;
                  dmag_q    <= dsr_mag_d;
                  rem_q     <= '0;
                  neg_quo_q <= dvd_neg_d ^ dsr_neg_d;
                  neg_rem_q <= dvd_neg_d;
                  // Internal flag captured now; the visible output follows
                  // together with the rest of the results.
                  dbz_q     <= dsr_zero_d;
                  cnt_q     <= CNT_W'(WIDTH);
                  busy_q    <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                  state_q   <= dsr_zero_d ? S_FIX : S_RUN;
`else
                  state_q   <= S_RUN;
`endif
               end
            end
            S_RUN: begin
               rem_q  <= rem_step_d;
               qacc_q <= qacc_step_d;
               cnt_q  <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               if (dbz_q) begin
                  quo_out_q <= '1;
                  rem_out_q <= dvd_q;
               end else begin
                  quo_out_q <= quo_res_d;
                  rem_out_q <= rem_res_d;
               end
               dbz_out_q <= dbz_q;
               cnt_q     <= '0;
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_out_q;
   assign remainder   = rem_out_q;
   assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq : self-checking bench for div_seq (WIDTH = 32)
// Results are compared against test-plan constants and against a plain
// arithmetic reference model (64-bit signed / unsigned division).
// -----------------------------------------------------------------------------
module tb_div_seq;

   localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
   localparam int DBZ_LAT = 1;
`else
   localparam int DBZ_LAT = W + 1;
`endif
   localparam int NRM_LAT = W + 1;  // edges after the accepting edge until done is seen

   logic         clock;
   logic         reset_n;
   logic         start;
   logic         is_signed;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_checks = 0;
   int n_errors = 0;

   div_seq #(.WIDTH(W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: ordinary integer arithmetic on 64-bit values.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, output logic [W-1:0] q,
                                   output logic [W-1:0] r, output logic z);
      longint sa, sb, qq, rr;
      if (b == '0) begin
         q = '1; r = a; z = 1'b1;
      end else if (!s) begin
         q = a / b; r = a % b; z = 1'b0;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         qq = sa / sb;
         rr = sa % sb;
         q = qq[W-1:0]; r = rr[W-1:0]; z = 1'b0;
      end
   endfunction

   // Issue one operation and wait (bounded) for done. lat = edges after the
   // accepting edge until done is observed (-1 on timeout); bcnt = busy samples.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int lat, output int bcnt, output logic [W-1:0] q,
                        output logic [W-1:0] r, output logic z);
      @(negedge clock);
      dividend = a; divisor = b; is_signed = s; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      bcnt = busy ? 1 : 0;
      lat = -1;
      for (int n = 1; n <= W + 10; n++) begin
         @(posedge clock); #1;
         if (done) begin lat = n; break; end
         if (busy) bcnt++;
      end
      q = quotient; r = remainder; z = div_by_zero;
      $display("op %08h / %08h s=%0d -> q=%08h r=%08h z=%0d lat=%0d busy=%0d",
               a, b, s, q, r, z, lat, bcnt);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", done); end
      n_checks++; if (quotient !== '0) begin n_errors++; $display("FAIL reset_quo got %08h exp 0", quotient); end
      n_checks++; if (remainder !== '0) begin n_errors++; $display("FAIL reset_rem got %08h exp 0", remainder); end
      n_checks++; if (div_by_zero !== 1'b0) begin n_errors++; $display("FAIL reset_dbz got %b exp 0", div_by_zero); end
      reset_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_directed;
      logic [W-1:0] ta [7] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
      logic [W-1:0] tb [7] = '{32'd7,   32'd7,        32'hFFFFFFF9, 32'hFFFFFFF9, 32'd2,  32'hFFFFFFFF, 32'h80000000};
      logic         ts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] eq [7] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14, 32'h7FFFFFFF, 32'h80000000, 32'd1};
      logic [W-1:0] er [7] = '{32'd2,  32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE, 32'd1, 32'd0, 32'd0};
      int lat, bcnt;
      logic [W-1:0] q, r;
      logic z;
      for (int i = 0; i < 7; i++) begin
         do_op(ta[i], tb[i], ts[i], lat, bcnt, q, r, z);
         n_checks++; if (q !== eq[i]) begin n_errors++; $display("FAIL dir%0d_quo got %08h exp %08h", i, q, eq[i]); end
         n_checks++; if (r !== er[i]) begin n_errors++; $display("FAIL dir%0d_rem got %08h exp %08h", i, r, er[i]); end
         n_checks++; if (z !== 1'b0) begin n_errors++; $display("FAIL dir%0d_dbz got %b exp 0", i, z); end
         n_checks++; if (lat !== NRM_LAT) begin n_errors++; $display("FAIL dir%0d_lat got %0d exp %0d", i, lat, NRM_LAT); end
         n_checks++; if (bcnt !== NRM_LAT) begin n_errors++; $display("FAIL dir%0d_busy got %0d exp %0d", i, bcnt, NRM_LAT); end
      end
   endtask

   task automatic test_div_zero;
      logic [W-1:0] ta [3] = '{32'd7, 32'hFFFFFF9C, 32'h12345678};
      logic         ts [3] = '{1'b0, 1'b1, 1'b1};
      int lat, bcnt;
      logic [W-1:0] q, r;
      logic z;
      for (int i = 0; i < 3; i++) begin
         do_op(ta[i], '0, ts[i], lat, bcnt, q, r, z);
         n_checks++; if (q !== '1) begin n_errors++; $display("FAIL dbz%0d_quo got %08h exp ffffffff", i, q); end
         n_checks++; if (r !== ta[i]) begin n_errors++; $display("FAIL dbz%0d_rem got %08h exp %08h", i, r, ta[i]); end
         n_checks++; if (z !== 1'b1) begin n_errors++; $display("FAIL dbz%0d_flag got %b exp 1", i, z); end
         n_checks++; if (lat !== DBZ_LAT) begin n_errors++; $display("FAIL dbz%0d_lat got %0d exp %0d", i, lat, DBZ_LAT); end
      end
   endtask

   task automatic test_random;
      int lat, bcnt, sel;
      logic [W-1:0] a, b, q, r, eq, er;
      logic s, z, ez;
      for (int i = 0; i < 40; i++) begin
         a = $urandom();
         s = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         if (sel < 4)       b = $urandom_range(1, 255);
         else if (sel < 6)  b = -($urandom_range(1, 255));
         else if (sel < 9)  b = $urandom();
         else               b = '0;
         ref_div(a, b, s, eq, er, ez);
         do_op(a, b, s, lat, bcnt, q, r, z);
         n_checks++; if (q !== eq) begin n_errors++; $display("FAIL rnd%0d_quo got %08h exp %08h", i, q, eq); end
         n_checks++; if (r !== er) begin n_errors++; $display("FAIL rnd%0d_rem got %08h exp %08h", i, r, er); end
         n_checks++; if (z !== ez) begin n_errors++; $display("FAIL rnd%0d_dbz got %b exp %b", i, z, ez); end
         n_checks++;
         if (lat !== (ez ? DBZ_LAT : NRM_LAT)) begin
            n_errors++; $display("FAIL rnd%0d_lat got %0d exp %0d", i, lat, ez ? DBZ_LAT : NRM_LAT);
         end
      end
   endtask

   task automatic test_ignore_start;
      int lat;
      @(negedge clock);
      dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = -1;
      for (int n = 1; n <= W + 10; n++) begin
         @(posedge clock); #1;
         start = 1'b0;
         if (done) begin lat = n; break; end
         if (n == 9) begin dividend = 32'd50; divisor = 32'd5; start = 1'b1; end
      end
      start = 1'b0;
      $display("ignore-start op: q=%0d r=%0d lat=%0d", quotient, remainder, lat);
      n_checks++; if (quotient !== 32'd14) begin n_errors++; $display("FAIL ign_quo got %0d exp 14", quotient); end
      n_checks++; if (remainder !== 32'd2) begin n_errors++; $display("FAIL ign_rem got %0d exp 2", remainder); end
      n_checks++; if (lat !== NRM_LAT) begin n_errors++; $display("FAIL ign_lat got %0d exp %0d", lat, NRM_LAT); end
   endtask

   task automatic test_back_to_back;
      int lat1, lat2;
      logic [W-1:0] q1, r1;
      @(negedge clock);
      dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat1 = -1;
      for (int n = 1; n <= W + 10; n++) begin
         @(posedge clock); #1;
         if (done) begin lat1 = n; break; end
      end
      q1 = quotient; r1 = remainder;
      // Request the next division in the done cycle itself.
      dividend = 32'd50; divisor = 32'd5; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL b2b_done_pulse got %b exp 0", done); end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
      lat2 = -1;
      for (int n = 1; n <= W + 10; n++) begin
         @(posedge clock); #1;
         if (done) begin lat2 = n; break; end
      end
      $display("back-to-back: first q=%0d r=%0d lat=%0d, second q=%0d r=%0d lat=%0d",
               q1, r1, lat1, quotient, remainder, lat2);
      n_checks++; if (q1 !== 32'd14) begin n_errors++; $display("FAIL b2b_q1 got %0d exp 14", q1); end
      n_checks++; if (r1 !== 32'd2) begin n_errors++; $display("FAIL b2b_r1 got %0d exp 2", r1); end
      n_checks++; if (quotient !== 32'd10) begin n_errors++; $display("FAIL b2b_q2 got %0d exp 10", quotient); end
      n_checks++; if (remainder !== 32'd0) begin n_errors++; $display("FAIL b2b_r2 got %0d exp 0", remainder); end
      n_checks++; if (lat2 !== NRM_LAT) begin n_errors++; $display("FAIL b2b_lat got %0d exp %0d", lat2, NRM_LAT); end
   endtask

   task automatic test_reset_mid_op;
      int dones, lat, bcnt;
      logic [W-1:0] q, r;
      logic z;
      // Outputs currently hold 10 r0, so a cleared result is observable.
      @(negedge clock);
      dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (14) @(posedge clock);
      #1;
      reset_n = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL midrst_done got %b exp 0", done); end
      n_checks++; if (quotient !== '0) begin n_errors++; $display("FAIL midrst_quo got %08h exp 0", quotient); end
      n_checks++; if (remainder !== '0) begin n_errors++; $display("FAIL midrst_rem got %08h exp 0", remainder); end
      dones = 0;
      for (int n = 0; n < W + 6; n++) begin
         @(posedge clock); #1;
         if (done || busy) dones++;
      end
      $display("mid-op reset: activity cycles after reset=%0d", dones);
      n_checks++; if (dones !== 0) begin n_errors++; $display("FAIL midrst_ghost got %0d exp 0", dones); end
      do_op(32'd1000, 32'd3, 1'b0, lat, bcnt, q, r, z);
      n_checks++; if (q !== 32'd333) begin n_errors++; $display("FAIL midrst_q got %0d exp 333", q); end
      n_checks++; if (r !== 32'd1) begin n_errors++; $display("FAIL midrst_r got %0d exp 1", r); end
      n_checks++; if (lat !== NRM_LAT) begin n_errors++; $display("FAIL midrst_lat got %0d exp %0d", lat, NRM_LAT); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
